// File: rtl/jtopl_eg_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jtopl_eg_step                                             |
// | Purpose  : Per-operator envelope stepping stage. Holds attenuation,  |
// |            envelope state and key edge flags, derives the effective  |
// |            rate and advances the attenuation once per sample.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module jtopl_eg_step #(
  parameter int CW = 15
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        keyon,
  input  logic        ksr,
  input  logic [3:0]  keycode,
  input  logic [4:0]  base_rate,
  input  logic [2:0]  state_next,
  output logic        keyon_now,
  output logic        keyoff_now,
  output logic [2:0]  state,
  output logic [9:0]  eg
);

  localparam logic [2:0] c_attack  = 3'b001;
  localparam logic [2:0] c_decay   = 3'b010;
  localparam logic [2:0] c_release = 3'b000;

  logic          r_keyon_last;
  logic [CW-1:0] r_cnt;

  logic [3:0]  w_ofs;
  logic [6:0]  w_rate_sum;
  logic [5:0]  w_rate;
  logic [3:0]  w_hi;
  logic [1:0]  w_lo;
  logic [7:0]  w_pat;
  logic [3:0]  w_s;
  logic [2:0]  w_idx;
  logic        w_upd;
  logic        w_p;
  logic [3:0]  w_inc;
  logic [10:0] w_d;
  logic [10:0] w_sum;

  // Effective rate: base rate doubled plus key-scale offset, saturated to 63
  always_comb begin
    w_ofs      = ksr ? keycode : {2'b00, keycode[3:2]};
    w_rate_sum = {1'b0, base_rate, 1'b0} + {3'b000, w_ofs};
    if (base_rate[4:1] == 4'd0)
      w_rate = 6'd0;
    else if (w_rate_sum > 7'd63)
      w_rate = 6'd63;
    else
      w_rate = w_rate_sum[5:0];
    w_hi = w_rate[5:2];
    w_lo = w_rate[1:0];
  end

  // Step pattern selected by the two fractional rate bits
  always_comb begin
    case (w_lo)
      2'd0:    w_pat = 8'b1010_1010;
      2'd1:    w_pat = 8'b1110_1010;
      2'd2:    w_pat = 8'b1110_1110;
      default: w_pat = 8'b1111_1110;
    endcase
  end

  // Slow rates: update gate and pattern index taken from counter bits above s
  always_comb begin
    w_s   = 4'd11 - w_hi;
    w_idx = 3'd0;
    w_upd = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (w_s == 4'(i)) begin
        w_idx = r_cnt[i+2 -: 3];
        w_upd = ((r_cnt & ~({CW{1'b1}} << i)) == '0);
      end
    end
  end

  // Attenuation increment for this sample
  always_comb begin
    w_inc = 4'd0;
    w_p   = 1'b0;
    if (w_hi == 4'd0) begin
      w_inc = 4'd0;
    end else if (w_hi <= 4'd11) begin
      w_p   = w_pat[w_idx];
      w_inc = (w_upd && w_p) ? 4'd1 : 4'd0;
    end else if (w_hi <= 4'd14) begin
      w_p = w_pat[r_cnt[2:0]];
      case (w_hi)
        4'd12:   w_inc = w_p ? 4'd2 : 4'd1;
        4'd13:   w_inc = w_p ? 4'd4 : 4'd2;
        default: w_inc = w_p ? 4'd8 : 4'd4;
      endcase
    end else begin
      w_inc = 4'd8;
    end
  end

  // Attack decrement scales with current attenuation; decay/release add
  always_comb begin
    w_d   = ({4'b0000, eg[9:3]} + 11'd1) * {7'b000_0000, w_inc};
    w_sum = {1'b0, eg} + {7'b000_0000, w_inc};
  end

  // Key edge detection and global sample counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_keyon_last <= 1'b0;
      keyon_now    <= 1'b0;
      keyoff_now   <= 1'b0;
      r_cnt        <= '0;
    end else if (cen) begin
      r_keyon_last <= keyon;
      keyon_now    <= keyon & ~r_keyon_last;
      keyoff_now   <= ~keyon & r_keyon_last;
      r_cnt        <= r_cnt + 1'b1;
    end
  end

  // Envelope state and attenuation update, driven by the controller's next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= c_release;
      eg    <= 10'h3FF;
    end else if (cen) begin
      state <= state_next;
      case (state_next)
        c_attack: begin
          if (w_rate >= 6'd60)
            eg <= 10'd0;
          else if ({1'b0, eg} > w_d)
            eg <= eg - w_d[9:0];
          else
            eg <= 10'd0;
        end
        c_decay, c_release: begin
          eg <= w_sum[10] ? 10'h3FF : w_sum[9:0];
        end
        default: eg <= eg;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtopl_eg_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_jtopl_eg_step                                          |
// | Purpose  : Self-checking bench for jtopl_eg_step with a small        |
// |            envelope controller closing the loop.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_jtopl_eg_step;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       keyon = 1'b0;
  logic       ksr = 1'b0;
  logic [3:0] keycode = 4'd0;
  logic [4:0] base_rate;
  logic [2:0] state_next;
  logic       keyon_now, keyoff_now;
  logic [2:0] state;
  logic [9:0] eg;

  // controller register file
  logic [3:0] arate = 4'd0, drate = 4'd0, rrate = 4'd0;
  logic [4:0] sl = 5'd0;
  logic       en_sus = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  bit chk = 1'b1;

  jtopl_eg_step #(.CW(15)) dut (
    .rst        (rst),
    .clk        (clk),
    .cen        (cen),
    .keyon      (keyon),
    .ksr        (ksr),
    .keycode    (keycode),
    .base_rate  (base_rate),
    .state_next (state_next),
    .keyon_now  (keyon_now),
    .keyoff_now (keyoff_now),
    .state      (state),
    .eg         (eg)
  );

  always #5 clk = ~clk;

  // envelope controller: picks next state and its rate
  always_comb begin
    state_next = state;
    base_rate  = 5'd0;
    if (keyon_now)       state_next = 3'b001;
    else if (keyoff_now) state_next = 3'b000;
    else begin
      case (state)
        3'b001: if (eg == 10'd0) state_next = 3'b010;
        3'b010: if (en_sus && eg[9:5] >= sl) state_next = 3'b100;
        3'b100: if (!en_sus) state_next = 3'b010;
        default: state_next = state;
      endcase
    end
    case (state_next)
      3'b001:  base_rate = {arate, 1'b0};
      3'b010:  base_rate = {drate, 1'b0};
      3'b000:  base_rate = {rrate, 1'b0};
      default: base_rate = 5'd0;
    endcase
  end

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int PAT [4] = '{8'b1010_1010, 8'b1110_1010, 8'b1110_1110, 8'b1111_1110};

  function automatic int eff_rate(input int br, input int ks, input int kc);
    int ofs, r;
    ofs = ks ? kc : kc / 4;
    if (br / 2 == 0) return 0;
    r = 2 * br + ofs;
    return (r > 63) ? 63 : r;
  endfunction

  function automatic int step_inc(input int rate, input int cnt);
    int hi, lo, per, bitv;
    if (rate < 4) return 0;
    hi = rate / 4;
    lo = rate % 4;
    if (hi <= 11) begin
      per = 1 << (11 - hi);
      if (cnt % per != 0) return 0;
      return (PAT[lo] >> ((cnt / per) % 8)) & 1;
    end
    if (hi <= 14) begin
      bitv = (PAT[lo] >> (cnt % 8)) & 1;
      return (1 << (hi - 12)) * (bitv ? 2 : 1);
    end
    return 8;
  endfunction

  int m_eg = 1023, m_state = 0, m_kon = 0, m_koff = 0, m_last = 0, m_cnt = 0;
  int m_rate, m_inc, m_d, m_sum;
  int s_keyon = 0, s_ksr = 0, s_kc = 0, s_br = 0, s_sn = 0, s_cen = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_eg = 1023; m_state = 0; m_kon = 0; m_koff = 0; m_last = 0; m_cnt = 0;
    end else if (s_cen != 0) begin
      m_rate = eff_rate(s_br, s_ksr, s_kc);
      m_inc  = step_inc(m_rate, m_cnt);
      m_kon  = (s_keyon != 0 && m_last == 0) ? 1 : 0;
      m_koff = (s_keyon == 0 && m_last != 0) ? 1 : 0;
      m_last = s_keyon;
      if (s_sn == 1) begin
        if (m_rate >= 60) m_eg = 0;
        else begin
          m_d  = (m_eg / 8 + 1) * m_inc;
          m_eg = (m_eg > m_d) ? m_eg - m_d : 0;
        end
      end else if (s_sn == 2 || s_sn == 0) begin
        m_sum = m_eg + m_inc;
        m_eg  = (m_sum > 1023) ? 1023 : m_sum;
      end
      m_state = s_sn;
      m_cnt   = (m_cnt + 1) % 32768;
    end
  end

  // compare outputs against the model, then sample inputs for the next edge
  always @(negedge clk) begin
    if (chk) begin
      check("eg", int'(eg), m_eg);
      check("state", int'(state), m_state);
      check("keyon_now", int'(keyon_now), m_kon);
      check("keyoff_now", int'(keyoff_now), m_koff);
    end
    s_keyon = int'(keyon);
    s_ksr   = int'(ksr);
    s_kc    = int'(keycode);
    s_br    = int'(base_rate);
    s_sn    = int'(state_next);
    s_cen   = int'(cen);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_eg_change(input int from, input int exp_v, input string nm);
    int k;
    k = 0;
    while (int'(eg) == from && k < 600) begin
      step(1);
      k++;
    end
    check(nm, int'(eg), exp_v);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    check("reset_eg", int'(eg), 1023);
    check("reset_state", int'(state), 0);
    check("reset_kon", int'(keyon_now), 0);
    step(4);
    check("release_idle_eg", int'(eg), 1023);

    // instant attack
    arate = 4'd15;
    keyon = 1'b1;
    step(1);
    check("inst_kon_pulse", int'(keyon_now), 1);
    step(1);
    check("inst_kon_gone", int'(keyon_now), 0);
    check("inst_state_att", int'(state), 1);
    check("inst_eg_zero", int'(eg), 0);
    step(1);
    check("inst_state_dec", int'(state), 2);

    // decay with key scaling: rate 12 then rate 6
    drate = 4'd1; keycode = 4'd8; ksr = 1'b1;
    step(2048);
    check("ksr1_decay_eg", int'(eg), 4);
    ksr = 1'b0;
    step(8192);
    check("ksr0_decay_eg", int'(eg), 10);

    // sustain hold
    en_sus = 1'b1; sl = 5'd2; drate = 4'd15; keycode = 4'd15; ksr = 1'b1;
    step(20);
    check("hold_state", int'(state), 4);
    check("hold_eg", int'(eg), 66);

    // key off, frozen release, then fast release with saturation
    keyon = 1'b0;
    step(1);
    check("koff_pulse", int'(keyoff_now), 1);
    step(1);
    check("koff_gone", int'(keyoff_now), 0);
    check("rel_state", int'(state), 0);
    step(50);
    check("rel_frozen_eg", int'(eg), 66);
    rrate = 4'd15;
    step(20);
    check("fast_rel_eg", int'(eg), 226);
    step(180);
    check("fast_rel_sat", int'(eg), 1023);

    // slow attack, rate 16
    rrate = 4'd0; arate = 4'd4; ksr = 1'b0; keycode = 4'd0;
    keyon = 1'b1;
    wait_eg_change(1023, 895, "slow_att_first");
    wait_eg_change(895, 783, "slow_att_second");

    // gapped cen: fast release and mid-range attack rates
    keyon = 1'b0; rrate = 4'd12;
    for (int i = 0; i < 200; i++) begin
      cen = (i % 3 != 2);
      step(1);
    end
    keyon = 1'b1; arate = 4'd13;
    for (int i = 0; i < 100; i++) begin
      cen = (i % 2 == 0);
      step(1);
    end
    arate = 4'd14; keyon = 1'b0;
    step(2);
    keyon = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cen = (i % 4 != 3);
      step(1);
    end
    cen = 1'b0;
    step(10);
    cen = 1'b1;

    // reset in the middle of decay
    arate = 4'd15; drate = 4'd3; keycode = 4'd0;
    step(30);
    rst = 1'b1;
    #1;
    check("async_rst_eg", int'(eg), 1023);
    check("async_rst_state", int'(state), 0);
    check("async_rst_kon", int'(keyon_now), 0);
    check("async_rst_koff", int'(keyoff_now), 0);
    step(2);
    rrate = 4'd0; arate = 4'd4;
    rst = 1'b0;
    step(128);
    check("post_rst_eg_hold", int'(eg), 1023);
    step(1);
    check("post_rst_first_step", int'(eg), 895);
    check("post_rst_state", int'(state), 1);
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtopl_eg_step.md
# jtopl_eg_step

Per-operator envelope stepping stage for the JTOPL envelope generator. It holds the operator's attenuation (`eg`) and envelope state registers, detects key-on/key-off edges, and feeds them to the combinational state controller. It then consumes the controller's `base_rate`/`state_next`, applies key-scale rate and the global sample counter, and advances the attenuation once per sample. Its output `eg` drives the operator level/attenuation path downstream.

## Interface
Parameters:
- `CW`, 15: width of the global envelope sample counter.

Ports:
- `rst`  in  1  reset, asynchronous, active-high.
- `clk`  in  1  system clock.
- `cen`  in  1  sample clock enable; every register changes only on `clk` with `cen=1`, except under `rst`.
- `keyon`  in  1  key level from the register file.
- `ksr`  in  1  key-scale rate select.
- `keycode`  in  4  block/F-number key code.
- `base_rate`  in  5  rate from the state controller.
- `state_next`  in  3  next state from the state controller.
- `keyon_now`  out  1  registered key-on rising edge, one `cen` period wide.
- `keyoff_now`  out  1  registered key-on falling edge, one `cen` period wide.
- `state`  out  3  envelope state. Encoding: 001 ATTACK, 010 DECAY, 100 HOLD, 000 RELEASE.
- `eg`  out  10  attenuation in 0.1875 dB steps. 0 is loudest; 0x3FF is silent.

## Operation
Reset values:
- `eg` = 0x3FF.
- `state` = RELEASE.
- `keyon_now` = 0, `keyoff_now` = 0.
- Internal `keyon_last` = 0, `cnt` = 0.

Edge detection, on each `cen`:
- `keyon_last <= keyon`.
- `keyon_now <= keyon & ~keyon_last`.
- `keyoff_now <= ~keyon & keyon_last`.

Global counter, on each `cen`:
- `cnt <= cnt + 1`, wrapping 0x7FFF to 0.
- The step tests below use the value of `cnt` before the increment.

Effective rate, combinational, result 0..63:
- `ofs` = `ksr` ? `keycode` : `keycode>>2`.
- If `base_rate[4:1]==0`, `rate` = 0.
- Otherwise `rate` = min(63, 2·`base_rate` + `ofs`), computed in 7 bits, then saturated.
- `hi` = `rate[5:2]`, `lo` = `rate[1:0]`.

Step pattern:
- Patterns P[lo], bit index 7..0:
  - P0 = 10101010
  - P1 = 11101010
  - P2 = 11101110
  - P3 = 11111110
- `rate` < 4: no update, `inc` = 0.
- `hi` ≤ 11, with s = 11 − `hi`:
  - Update only when `cnt[s-1:0]==0`; s=0 means every `cen`.
  - `p` = P[lo][`cnt[s+2:s]`].
  - `inc` = `p`.
- `hi` 12..14: update every `cen`.
  - `p` = P[lo][`cnt[2:0]`].
  - `inc` = (1 << (`hi`−12)) << `p`.
- `hi` = 15: `inc` = 8 every `cen`.

Update on `cen`. `state <= state_next` always. The attenuation update uses `state_next`:
- ATTACK:
  - If `rate` ≥ 60, `eg <= 0`.
  - Otherwise `d` = ((`eg`>>3)+1)·`inc`, and `eg <= (eg > d) ? eg−d : 0`.
- DECAY or RELEASE: `eg <= min(0x3FF, eg + inc)`, using 11-bit intermediate arithmetic.
- HOLD: `eg` unchanged.

Boundary conditions:
- `inc` = 0 leaves `eg` unchanged in every state.
- `eg` does not re-initialise on key-on; attack starts from the current `eg`.
- A key toggled faster than `cen` is not seen; only sampled levels count.
- `rst` at any time forces the reset values on the next edge. Operation resumes from RELEASE with `eg`=0x3FF.

## Timing
- All outputs are registered, with zero combinational path from inputs to outputs.
- The key-on sample at `cen` n gives `keyon_now`=1 after `cen` n.
- The controller sees that pulse during cycles to `cen` n+1, so `state` = ATTACK and the first attack step happen at `cen` n+1.
- `keyon_now` and `keyoff_now` are never both 1.
- Loop latency is one `cen` period: `state`/`eg` → controller → `base_rate`/`state_next` → registers.
- With `cen` held low, all state freezes, including `cnt`.

## Test plan
- Reset: assert `rst` mid-decay with `cen` running → `eg`=0x3FF, `state`=000, both pulses 0 immediately. The counter restarts at 0 after release.
- Instant attack: controller model, `arate`=15, `keyon` rises → `keyon_now` high for one `cen`; `state`=001 and `eg`=0 at the next `cen`, then DECAY on the following one.
- Slow attack: `arate`=4, `ksr`=0, `keycode`=0 (rate 16, `hi` 4, s=7) → `eg` changes only on `cen`s where `cnt[6:0]`=0. First step from 0x3FF subtracts 128·`p`.
- Decay rate and KSR: `drate`=1, `keycode`=8, `ksr`=1 → rate 12, `hi` 3, s=8, `lo` 0. Measured average is +1 per 512 `cen`s; with `ksr`=0 (rate 6, `hi` 1, s=10, `lo` 2) it is 3 per 4096.
- Fast decay: `drate`=15, `keycode`=15, `ksr`=1 (rate 63) → `eg` +8 every `cen`, saturating at exactly 0x3FF with no wrap.
- Key-off and hold: `en_sus`=1, `sl`=2 → `state` HOLD with `eg` constant once `eg[9:5]` ≥ 2. `keyon` falls → `keyoff_now` pulse, then RELEASE stepping with `rrate`. `rrate`=0 → `eg` frozen.
